vector_mem_engine: RTL

//  Parametrised element-wise vector processor for embedded-memory experiments. On a start

---
 rtl/vector_mem_engine_if.sv | 35 +++
 rtl/vector_mem_engine.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vector_mem_engine_if.sv
// Bus bundle between the vector engine, its start/length/mode controls and the A/B/Y RAMs.
`default_nettype none

interface vector_mem_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  logic              START_I;
  logic [ADDR_W-1:0] LEN_I;
  logic [1:0]        MODE_I;
  logic [ADDR_W-1:0] RD_ADDR_O;
  logic              RD_EN_O;
  logic [DATA_W-1:0] A_RDATA_I;
  logic [DATA_W-1:0] B_RDATA_I;
  logic [ADDR_W-1:0] WR_ADDR_O;
  logic [DATA_W-1:0] WR_DATA_O;
  logic              WR_EN_O;
  logic              BUSY_O;
  logic              DONE_O;
  logic [ADDR_W:0]   SAT_COUNT_O;

  modport slave (
    input  START_I, LEN_I, MODE_I, A_RDATA_I, B_RDATA_I,
    output RD_ADDR_O, RD_EN_O, WR_ADDR_O, WR_DATA_O, WR_EN_O,
           BUSY_O, DONE_O, SAT_COUNT_O
  );

  modport master (
    output START_I, LEN_I, MODE_I, A_RDATA_I, B_RDATA_I,
    input  RD_ADDR_O, RD_EN_O, WR_ADDR_O, WR_DATA_O, WR_EN_O,
           BUSY_O, DONE_O, SAT_COUNT_O
  );
endinterface

`default_nettype wire

// File: rtl/vector_mem_engine.sv
// ----------------------------------------------------------------------------
// vector_mem_engine : element-wise A op B -> Y streamer over synchronous RAMs
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module vector_mem_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  wire logic             CLOCK_50_I,
  input  wire logic             RESET_I,
  vector_mem_engine_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_start_d;
  logic [ADDR_W-1:0] r_last;
  logic [1:0]        r_mode;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_p_vld;
  logic [ADDR_W-1:0] r_p_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_drain_cnt;
  logic [ADDR_W:0]   r_sat_cnt;

  logic              w_start_edge;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_result;
  logic              w_clip;

  assign w_start_edge = bus.START_I & ~r_start_d;
  assign w_sum        = {1'b0, bus.A_RDATA_I} + {1'b0, bus.B_RDATA_I};

  always_comb begin
    w_result = w_sum[DATA_W-1:0];
    w_clip   = 1'b0;
    case (r_mode)
      2'd1: w_result = bus.A_RDATA_I - bus.B_RDATA_I;
      2'd2: begin
        if (w_sum[DATA_W]) begin
          w_result = {DATA_W{1'b1}};
          w_clip   = 1'b1;
        end
      end
      2'd3: w_result = ($signed(bus.A_RDATA_I) > $signed(bus.B_RDATA_I))
                       ? bus.A_RDATA_I : bus.B_RDATA_I;
      default: w_result = w_sum[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_last      <= '0;
      r_mode      <= 2'd0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_p_vld     <= 1'b0;
      r_p_addr    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_sat_cnt   <= '0;
    end else begin
      r_start_d <= bus.START_I;

      // Two-stage pipe: RAM data lands one cycle after the read, result is registered once more.
      r_p_vld   <= r_rd_en;
      r_p_addr  <= r_rd_addr;
      r_wr_en   <= r_p_vld;
      r_wr_addr <= r_p_addr;
      r_wr_data <= w_result;
      if (r_p_vld && w_clip) begin
        r_sat_cnt <= r_sat_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_edge) begin
            // LEN of zero wraps to all-ones, giving the full 2**ADDR_W elements.
            r_last    <= bus.LEN_I - 1'b1;
            r_mode    <= bus.MODE_I;
            r_sat_cnt <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_rd_addr == r_last) begin
            r_rd_en     <= 1'b0;
            r_drain_cnt <= 1'b0;
            r_state     <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.RD_ADDR_O   = r_rd_addr;
  assign bus.RD_EN_O     = r_rd_en;
  assign bus.WR_ADDR_O   = r_wr_addr;
  assign bus.WR_DATA_O   = r_wr_data;
  assign bus.WR_EN_O     = r_wr_en;
  assign bus.BUSY_O      = r_busy;
  assign bus.DONE_O      = r_done;
  assign bus.SAT_COUNT_O = r_sat_cnt;

endmodule

`default_nettype wire
